de0qsys_key_pio: RTL

Avalon-MM slave input port for the DE0 push-buttons, the counterpart to the display output ports on the same system interconnect. It synchronizes and debounces the asynchronous `in_port` pins and exposes the debounced level as a readable data register. It also latches qualifying edges into a capture register and raises a level interrupt to the Nios II through a per-bit mask.

---
 rtl/de0qsys_key_pio.sv | 124 ++++++++++++
 1 files changed

// File: rtl/de0qsys_key_pio.sv
// Avalon-MM push-button input port: synchronizes and debounces the key pins,
// latches qualifying edges, and raises a masked level interrupt.
module de0qsys_key_pio #(
    parameter int unsigned      WIDTH           = 3,
    parameter int unsigned      DEBOUNCE_CYCLES = 50000,
    parameter int unsigned      EDGE_TYPE       = 1,
    parameter logic [WIDTH-1:0] IDLE_LEVEL      = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int unsigned      CNT_W        = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_DONE     = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [1:0]       ADDR_DATA    = 2'd0;
    localparam logic [1:0]       ADDR_IRQMASK = 2'd2;
    localparam logic [1:0]       ADDR_EDGECAP = 2'd3;

    logic [WIDTH-1:0]            s1;
    logic [WIDTH-1:0]            s2;
    logic [WIDTH-1:0]            db;
    logic [WIDTH-1:0]            db_next;
    logic [WIDTH-1:0][CNT_W-1:0] cnt;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_next;
    logic [WIDTH-1:0]            irq_mask;
    logic [WIDTH-1:0]            edge_cap;
    logic [WIDTH-1:0]            edge_cap_next;
    logic [WIDTH-1:0]            edge_set;
    logic [WIDTH-1:0]            w1c;
    logic [WIDTH-1:0]            rise;
    logic [WIDTH-1:0]            fall;
    logic                        wr_en;
    logic                        unused_wdata;

    assign unused_wdata = ^writedata;

    // Two-flop synchronizer on the raw pins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= IDLE_LEVEL;
            s2 <= IDLE_LEVEL;
        end else begin
            s1 <= in_port;
            s2 <= s1;
        end
    end

    // Per-bit stability counter; any return to the debounced level restarts it
    always_comb begin
        db_next  = db;
        cnt_next = cnt;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (s2[i] == db[i]) begin
                cnt_next[i] = '0;
            end else if (cnt[i] + CNT_W'(1) == CNT_DONE) begin
                db_next[i]  = s2[i];
                cnt_next[i] = '0;
            end else begin
                cnt_next[i] = cnt[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db  <= IDLE_LEVEL;
            cnt <= '0;
        end else begin
            db  <= db_next;
            cnt <= cnt_next;
        end
    end

    assign rise = ~db & db_next;
    assign fall = db & ~db_next;

    always_comb begin
        edge_set = '0;
        case (EDGE_TYPE)
            0:       edge_set = rise;
            1:       edge_set = fall;
            default: edge_set = rise | fall;
        endcase
    end

    assign wr_en = chipselect & ~write_n;
    assign w1c   = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

    // A new edge wins over a same-cycle clear so no event is dropped
    assign edge_cap_next = (edge_cap & ~w1c) | edge_set;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask <= '0;
            edge_cap <= '0;
        end else begin
            edge_cap <= edge_cap_next;
            if (wr_en && address == ADDR_IRQMASK) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
        end
    end

    assign irq = |(edge_cap & irq_mask);

    // Zero-latency read mux, independent of chipselect
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata = 32'(db);
            ADDR_IRQMASK: readdata = 32'(irq_mask);
            ADDR_EDGECAP: readdata = 32'(edge_cap);
            default:      readdata = '0;
        endcase
    end

endmodule
